// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared widths, digit limits and mode encodings for the mm:ss timer
package timer_pkg;

  localparam int DIGIT_W          = 4;
  localparam int DEFAULT_TICK_DIV = 50_000_000;

  localparam logic [DIGIT_W-1:0] MAX_TENS  = 4'd5;
  localparam logic [DIGIT_W-1:0] MAX_UNITS = 4'd9;

  typedef enum logic [1:0] {
    MODE_CLEAR = 2'd0,
    MODE_SET   = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_t;

endpackage

// File: rtl/bcd_mod60_counter.sv
// rtl/bcd_mod60_counter.sv - two-digit BCD counter 00..59 with wrap-up, saturating-down and load-59
module bcd_mod60_counter
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               inc,
  input  logic               dec,
  input  logic               load59,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] units,
  output logic               isZero
);

  logic [DIGIT_W-1:0] r_tens;
  logic [DIGIT_W-1:0] r_units;
  logic               w_zero;

  assign w_zero = (r_tens == '0) && (r_units == '0);

  // Down-count saturates at 00; the borrow into the other field is decided by the parent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tens  <= '0;
      r_units <= '0;
    end else if (clear) begin
      r_tens  <= '0;
      r_units <= '0;
    end else if (load59) begin
      r_tens  <= MAX_TENS;
      r_units <= MAX_UNITS;
    end else if (inc) begin
      if (r_units == MAX_UNITS) begin
        r_units <= '0;
        r_tens  <= (r_tens == MAX_TENS) ? '0 : r_tens + 1'b1;
      end else begin
        r_units <= r_units + 1'b1;
      end
    end else if (dec && !w_zero) begin
      if (r_units == '0) begin
        r_units <= MAX_UNITS;
        r_tens  <= r_tens - 1'b1;
      end else begin
        r_units <= r_units - 1'b1;
      end
    end
  end

  assign tens   = r_tens;
  assign units  = r_units;
  assign isZero = w_zero;

endmodule

// File: rtl/mmss_timer_counter.sv
// rtl/mmss_timer_counter.sv - mm:ss set/countdown timer with one-second prescaler and timeUp flag
module mmss_timer_counter
  import timer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enableCounter,
  input  logic               forward,
  input  logic               resetTimer,
  input  logic               incrementSeg,
  input  logic               incrementMin,
  output logic [DIGIT_W-1:0] secUnits,
  output logic [DIGIT_W-1:0] secTens,
  output logic [DIGIT_W-1:0] minUnits,
  output logic [DIGIT_W-1:0] minTens,
  output logic               timeUp
);

  localparam int             PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

  mode_t         w_mode;
  logic          r_prev_seg;
  logic          r_prev_min;
  logic [PW-1:0] r_presc;
  logic          r_time_up;
  logic          w_seg_rise;
  logic          w_min_rise;
  logic          w_set;
  logic          w_clear;
  logic          w_tick;
  logic          w_sec_zero;
  logic          w_min_zero;
  logic          w_borrow;
  logic          w_reaches_zero;

  always_comb begin
    w_mode = MODE_HOLD;
    if (resetTimer)                     w_mode = MODE_CLEAR;
    else if (enableCounter && forward)  w_mode = MODE_SET;
    else if (enableCounter)             w_mode = MODE_COUNT;
  end

  assign w_clear    = (w_mode == MODE_CLEAR);
  assign w_set      = (w_mode == MODE_SET);
  assign w_seg_rise = incrementSeg && !r_prev_seg;
  assign w_min_rise = incrementMin && !r_prev_min;
  assign w_tick     = (w_mode == MODE_COUNT) && (r_presc == LAST);

  // prev registers reset high so idle-high increment levels are not seen as edges after release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_seg <= 1'b1;
      r_prev_min <= 1'b1;
    end else begin
      r_prev_seg <= incrementSeg;
      r_prev_min <= incrementMin;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else begin
      case (w_mode)
        MODE_COUNT: r_presc <= (r_presc == LAST) ? '0 : r_presc + 1'b1;
        MODE_HOLD:  r_presc <= r_presc;
        default:    r_presc <= '0;
      endcase
    end
  end

  assign w_borrow       = w_tick && w_sec_zero && !w_min_zero;
  assign w_reaches_zero = w_min_zero &&
                          (w_sec_zero || ((secTens == '0) && (secUnits == 4'd1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_time_up <= 1'b0;
    end else if (w_clear) begin
      r_time_up <= 1'b0;
    end else if (w_set && (w_seg_rise || w_min_rise)) begin
      r_time_up <= 1'b0;
    end else if (w_tick && w_reaches_zero) begin
      r_time_up <= 1'b1;
    end
  end

  bcd_mod60_counter u_sec (
    .clk    (clk),
    .rst    (reset),
    .clear  (w_clear),
    .inc    (w_set && w_seg_rise),
    .dec    (w_tick && !w_sec_zero),
    .load59 (w_borrow),
    .tens   (secTens),
    .units  (secUnits),
    .isZero (w_sec_zero)
  );

  bcd_mod60_counter u_min (
    .clk    (clk),
    .rst    (reset),
    .clear  (w_clear),
    .inc    (w_set && w_min_rise),
    .dec    (w_borrow),
    .load59 (1'b0),
    .tens   (minTens),
    .units  (minUnits),
    .isZero (w_min_zero)
  );

  assign timeUp = r_time_up;

endmodule

// File: tb/tb_mmss_timer_counter.sv
// tb/tb_mmss_timer_counter.sv - directed and randomized bench for mmss_timer_counter
module tb_mmss_timer_counter;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enableCounter = 1'b0;
  logic forward = 1'b0;
  logic resetTimer = 1'b0;
  logic incrementSeg = 1'b1;
  logic incrementMin = 1'b1;
  logic [3:0] secUnits, secTens, minUnits, minTens;
  logic timeUp;

  int m_mm, m_ss, m_pc;
  bit m_tu, m_ps, m_pm;
  int n_checks = 0;
  int n_fail = 0;

  mmss_timer_counter #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .enableCounter(enableCounter), .forward(forward),
    .resetTimer(resetTimer), .incrementSeg(incrementSeg), .incrementMin(incrementMin),
    .secUnits(secUnits), .secTens(secTens), .minUnits(minUnits), .minTens(minTens),
    .timeUp(timeUp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd(input int mm, input int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] disp();
    return {minTens, minUnits, secTens, secUnits};
  endfunction

  task automatic model_reset();
    m_mm = 0; m_ss = 0; m_pc = 0; m_tu = 0; m_ps = 1; m_pm = 1;
  endtask

  // Reference: value held as total seconds, prescaler as a plain cycle count.
  task automatic model_edge();
    bit sr, mr;
    int total;
    sr = incrementSeg && !m_ps;
    mr = incrementMin && !m_pm;
    m_ps = incrementSeg;
    m_pm = incrementMin;
    if (resetTimer) begin
      m_mm = 0; m_ss = 0; m_tu = 0; m_pc = 0;
    end else if (enableCounter && forward) begin
      m_pc = 0;
      if (sr) m_ss = (m_ss + 1) % 60;
      if (mr) m_mm = (m_mm + 1) % 60;
      if (sr || mr) m_tu = 0;
    end else if (enableCounter) begin
      if (m_pc == TD - 1) begin
        m_pc = 0;
        total = m_mm * 60 + m_ss;
        if (total > 0) total--;
        if (total == 0) m_tu = 1;
        m_mm = total / 60;
        m_ss = total % 60;
      end else begin
        m_pc++;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit f, input bit s, input bit m);
    resetTimer = r; enableCounter = e; forward = f; incrementSeg = s; incrementMin = m;
    @(posedge clk);
    model_edge();
    #1;
    check_eq("disp", disp(), bcd(m_mm, m_ss));
    check_eq("time_up", timeUp, m_tu);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("async_rst_disp", disp(), 16'h0000);
    check_eq("async_rst_tu", timeUp, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic pulse(input bit s, input bit m);
    cyc(0, 1, 1, s ? 1'b0 : 1'b1, m ? 1'b0 : 1'b1);
    cyc(0, 1, 1, 1, 1);
  endtask

  task automatic run(input bit e, input bit f, input int n);
    repeat (n) cyc(0, e, f, 1, 1);
  endtask

  task automatic clr();
    cyc(1, 0, 0, 1, 1);
  endtask

  task automatic expect_val(input string tag, input int mm, input int ss, input bit t);
    check_eq(tag, disp(), bcd(mm, ss));
    check_eq({tag, "_tu"}, timeUp, t);
  endtask

  initial begin
    model_reset();
    #2;
    expect_val("reset_state", 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run(1, 1, 3);
    expect_val("no_spurious_inc", 0, 0, 0);

    repeat (3) pulse(0, 1);
    repeat (61) pulse(1, 0);
    expect_val("set_03_01", 3, 1, 0);

    clr();
    pulse(0, 1);
    expect_val("set_01_00", 1, 0, 0);
    run(1, 0, 3);
    expect_val("count_3clk", 1, 0, 0);
    run(1, 0, 1);
    expect_val("count_00_59", 0, 59, 0);
    run(1, 0, 4);
    expect_val("count_00_58", 0, 58, 0);
    run(0, 0, 20);
    expect_val("hold_00_58", 0, 58, 0);

    clr();
    repeat (2) pulse(1, 0);
    run(1, 0, 4);
    expect_val("count_00_01", 0, 1, 0);
    run(1, 0, 4);
    expect_val("count_00_00", 0, 0, 1);
    run(1, 0, 8);
    expect_val("stay_00_00", 0, 0, 1);
    pulse(1, 0);
    expect_val("set_clears_tu", 0, 1, 0);

    clr();
    repeat (5) pulse(0, 1);
    repeat (30) pulse(1, 0);
    expect_val("set_05_30", 5, 30, 0);
    run(1, 0, 2);
    cyc(1, 1, 0, 1, 1);
    expect_val("clear_mid_count", 0, 0, 0);
    run(1, 0, 3);
    expect_val("presc_restart", 0, 0, 0);
    run(1, 0, 1);
    expect_val("tick_at_zero", 0, 0, 1);

    clr();
    repeat (3) pulse(1, 0);
    run(1, 0, 3);
    do_reset();
    run(0, 0, 4);
    expect_val("async_abort", 0, 0, 0);

    repeat (59) pulse(1, 1);
    expect_val("set_59_59", 59, 59, 0);
    pulse(1, 1);
    expect_val("both_wrap", 0, 0, 0);

    repeat (10) pulse(1, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, i[0], ~i[0]);
    expect_val("inc_ignored_count", 0, 8, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmss_timer_counter.md
MMSS_TIMER_COUNTER -- requirements
Module: mmss_timer_counter

Interface
REQ-001 Parameter: TICK_DIV, default 50_000_000, clk cycles per one-second countdown tick.
REQ-002 Port: clk  input  1  rising-edge system clock; the block uses one clock only.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: enableCounter  input  1  counter enable from the timer control FSM.
REQ-005 Port: forward  input  1  setting mode from the control FSM (1 = manual set, 0 = countdown).
REQ-006 Port: resetTimer  input  1  synchronous clear of the time value.
REQ-007 Port: incrementSeg  input  1  level from the FSM; each rising edge adds one second.
REQ-008 Port: incrementMin  input  1  level from the FSM; each rising edge adds one minute.
REQ-009 Port: secUnits, secTens, minUnits, minTens  output  4 each  BCD digits of the displayed mm:ss value.
REQ-010 Port: timeUp  output  1  countdown reached 00:00.

Function
REQ-011 All outputs SHALL be registered, and every update SHALL appear one clk after its causing edge.
REQ-012 The block SHALL decode its operating mode with this priority: resetTimer=1 -> CLEAR; else enableCounter=1 & forward=1 -> SET; else enableCounter=1 & forward=0 -> COUNT; else HOLD.
REQ-013 CLEAR SHALL force all digits to 0, clear timeUp, and clear the prescaler.
REQ-014 The block SHALL keep edge detectors for the increment inputs: a prevSeg/prevMin register each, with a rising edge defined as input=1 & prev=0; prev registers SHALL update every cycle in all modes.
REQ-015 SET SHALL add one second on an incrementSeg rising edge, wrapping 59->00 with no carry into minutes.
REQ-016 SET SHALL add one minute on an incrementMin rising edge, wrapping 59->00.
REQ-017 If both increment edges occur in the same cycle in SET, both fields SHALL increment.
REQ-018 Any increment in SET SHALL clear timeUp.
REQ-019 Increment edges outside SET SHALL be ignored.
REQ-020 Prescaler: SHALL count 0..TICK_DIV-1 only in COUNT, SHALL pulse an internal tick on the terminal count, and SHALL be held at 0 in every other mode, so the first tick after COUNT entry occurs TICK_DIV cycles later.
REQ-021 A COUNT tick with seconds>0 SHALL decrement the seconds.
REQ-022 A COUNT tick with seconds=0 and minutes>0 SHALL decrement the minutes and set the seconds to 59.
REQ-023 A COUNT tick at 00:00 SHALL leave the value unchanged.
REQ-024 timeUp SHALL set on the COUNT tick that produces 00:00 and on any COUNT tick taken at 00:00.
REQ-025 timeUp SHALL remain set until CLEAR or a SET increment.
REQ-026 HOLD SHALL freeze the digits, timeUp, and the prescaler value.
REQ-027 A BCD digit SHALL never exceed 9, and a tens digit SHALL never exceed 5.

Reset
REQ-028 On reset assertion the block SHALL asynchronously set the digits to 0, timeUp to 0, and the prescaler to 0.
REQ-029 On reset assertion prevSeg and prevMin SHALL be set to 1, so that the FSM's idle-high increment levels cause no spurious increment after release.
REQ-030 The block SHALL resume normal operation on the first clk edge after reset deassertion; reset asserted mid-countdown SHALL abort the countdown with no tick emitted.

Structure
REQ-031 Shared package timer_pkg SHALL hold: the BCD digit width (4), MAX_TENS=5, MAX_UNITS=9, the mode encodings CLEAR/SET/COUNT/HOLD, and the default TICK_DIV.
REQ-032 One sub-module, bcd_mod60_counter, SHALL be instantiated twice (seconds and minutes), with inputs clear, inc, dec, load59 and outputs tens, units, isZero.
REQ-033 The top level SHALL contain the mode decode, edge detectors, prescaler, borrow logic, and timeUp.

Verification (TICK_DIV=4)
REQ-034 Reset with incrementSeg=incrementMin=1, then release -> digits stay 00:00 and timeUp=0.
REQ-035 SET with 3 incrementMin pulses and 61 incrementSeg pulses -> display 03:01 (seconds wrap 59->00, minutes unchanged by the wrap).
REQ-036 From 01:00, COUNT -> 00:59 after 4 clk, then 00:58 after 4 more clk; HOLD for 20 clk -> the value stays 00:58.
REQ-037 From 00:02, COUNT -> 00:01, then 00:00 with timeUp=1; further ticks keep 00:00 and timeUp=1; one incrementSeg pulse in SET -> 00:01 and timeUp=0.
REQ-038 At 05:30 in COUNT, assert resetTimer for 1 cycle -> 00:00 on the next clk and the prescaler restarts; reset asserted mid-prescale -> immediate 00:00 with no tick emitted.
REQ-039 In SET with both increments rising in the same cycle from 59:59 -> 00:00; increment pulses during COUNT -> value unaffected.
